apu_frame_counter: RTL and testbench

CPU-bus responder implementing the APU frame sequencer registers ($4017 write, $4015 bit-6 read). Sits on the CPU's address/data/rw bus alongside RAM and PPU decode, counts enabled CPU cycles, emits quarter-/half-frame strobes to the APU channel units, and drives the CPU's `i_irq_n` line with the frame IRQ.

---
 rtl/apu_pkg.sv | 23 ++
 rtl/apu_frame_counter.sv | 102 ++++++++++
 tb/tb_apu_frame_counter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apu_pkg.sv
// Shared APU definitions: CPU-visible register addresses, frame sequencer
// step defaults, mode encoding and the step-event bundle.
package apu_pkg;

    localparam logic [15:0] APU_STATUS_ADDR = 16'h4015;
    localparam logic [15:0] APU_FRAME_ADDR  = 16'h4017;

    localparam int DEFAULT_STEP1 = 7457;
    localparam int DEFAULT_STEP2 = 14913;
    localparam int DEFAULT_STEP3 = 22371;
    localparam int DEFAULT_STEP4 = 29829;
    localparam int DEFAULT_STEP5 = 37281;

    localparam logic FRAME_MODE_4STEP = 1'b0;
    localparam logic FRAME_MODE_5STEP = 1'b1;

    typedef struct packed {
        logic quarter;
        logic half;
        logic irq;
    } step_event_t;

endpackage

// File: rtl/apu_frame_counter.sv
// APU frame sequencer: counts enabled CPU cycles, emits quarter/half-frame
// strobes, raises the frame IRQ and serves the $4017 write / $4015 bit-6 read.
module apu_frame_counter
    import apu_pkg::*;
#(
    parameter int STEP1 = DEFAULT_STEP1,
    parameter int STEP2 = DEFAULT_STEP2,
    parameter int STEP3 = DEFAULT_STEP3,
    parameter int STEP4 = DEFAULT_STEP4,
    parameter int STEP5 = DEFAULT_STEP5
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clk_en,
    input  logic        i_rw,
    input  logic [15:0] i_address,
    input  logic [7:0]  i_data,
    output logic [7:0]  o_data,
    output logic        o_data_valid,
    output logic        o_irq_n,
    output logic        o_quarter_frame,
    output logic        o_half_frame
);

    localparam logic [15:0] STEP1_C = 16'(STEP1);
    localparam logic [15:0] STEP2_C = 16'(STEP2);
    localparam logic [15:0] STEP3_C = 16'(STEP3);
    localparam logic [15:0] STEP4_C = 16'(STEP4);
    localparam logic [15:0] STEP5_C = 16'(STEP5);

    logic [15:0] count;
    logic [15:0] last_step;
    logic        mode;
    logic        irq_inhibit;
    logic        frame_irq;
    logic        quarter_q;
    logic        half_q;
    logic        status_read;
    logic        frame_write;
    logic        unused_data_bits;
    step_event_t step_event;

    assign last_step        = (mode == FRAME_MODE_5STEP) ? STEP5_C : STEP4_C;
    assign status_read      = i_rw && (i_address == APU_STATUS_ADDR);
    assign frame_write      = !i_rw && (i_address == APU_FRAME_ADDR);
    assign unused_data_bits = ^i_data[5:0];

    // In 5-step mode STEP4 is not the last step and so decodes to nothing.
    always_comb begin
        step_event = '0;
        if (count == STEP1_C || count == STEP3_C) begin
            step_event.quarter = 1'b1;
        end
        if (count == STEP2_C || count == last_step) begin
            step_event.quarter = 1'b1;
            step_event.half    = 1'b1;
        end
        if (mode == FRAME_MODE_4STEP && !irq_inhibit && count == STEP4_C) begin
            step_event.irq = 1'b1;
        end
    end

    // A $4017 write pre-empts whatever the old count would have produced;
    // otherwise an IRQ set takes priority over a coincident $4015 read clear.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            count       <= '0;
            mode        <= FRAME_MODE_4STEP;
            irq_inhibit <= 1'b0;
            frame_irq   <= 1'b0;
            quarter_q   <= 1'b0;
            half_q      <= 1'b0;
        end else if (i_clk_en) begin
            if (frame_write) begin
                count       <= '0;
                mode        <= i_data[7];
                irq_inhibit <= i_data[6];
                quarter_q   <= i_data[7];
                half_q      <= i_data[7];
                if (i_data[6]) begin
                    frame_irq <= 1'b0;
                end
            end else begin
                count     <= (count == last_step) ? '0 : count + 16'd1;
                quarter_q <= step_event.quarter;
                half_q    <= step_event.half;
                if (step_event.irq) begin
                    frame_irq <= 1'b1;
                end else if (status_read) begin
                    frame_irq <= 1'b0;
                end
            end
        end
    end

    assign o_data          = status_read ? {1'b0, frame_irq, 6'b0} : 8'h00;
    assign o_data_valid    = status_read;
    assign o_irq_n         = ~frame_irq;
    assign o_quarter_frame = quarter_q;
    assign o_half_frame    = half_q;

endmodule

// File: tb/tb_apu_frame_counter.sv
// Self-checking bench for apu_frame_counter; runs with shortened step
// constants so every period fits in a few hundred cycles.
module tb_apu_frame_counter;
    import apu_pkg::*;

    localparam int S1 = 57;
    localparam int S2 = 113;
    localparam int S3 = 171;
    localparam int S4 = 229;
    localparam int S5 = 281;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_en = 1'b0;
    logic        rw = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        irq_n;
    logic        quarter;
    logic        half;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int at;
        bit q;
        bit h;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] exp_data_q[$];

    apu_frame_counter #(
        .STEP1(S1), .STEP2(S2), .STEP3(S3), .STEP4(S4), .STEP5(S5)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_clk_en       (clk_en),
        .i_rw           (rw),
        .i_address      (address),
        .i_data         (data_in),
        .o_data         (data_out),
        .o_data_valid   (data_valid),
        .o_irq_n        (irq_n),
        .o_quarter_frame(quarter),
        .o_half_frame   (half)
    );

    always #5 clk = ~clk;

    task automatic tick(input logic en);
        clk_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        rw      = 1'b0;
        address = 16'h0000;
        data_in = 8'h00;
    endtask

    task automatic write_frame(input logic [7:0] value);
        rw      = 1'b0;
        address = APU_FRAME_ADDR;
        data_in = value;
        tick(1'b1);
        bus_idle();
    endtask

    task automatic push_ev(input int at, input bit q, input bit h);
        ev_t e;
        e.at = at;
        e.q  = q;
        e.h  = h;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus_idle();
        repeat (3) tick(1'b1);
        total++;
        if (irq_n !== 1'b1 || quarter !== 1'b0 || half !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: irq_n=%b q=%b h=%b, required irq_n=1 q=0 h=0", irq_n, quarter, half);
        end
        total++;
        if (data_out !== 8'h00 || data_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_bus: data=%h valid=%b, required data=00 valid=0", data_out, data_valid);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_four_step();
        ev_t e;
        int  irq_at = -1;
        push_ev(S1 + 1, 1, 0);
        push_ev(S2 + 1, 1, 1);
        push_ev(S3 + 1, 1, 0);
        push_ev(S4 + 1, 1, 1);
        push_ev(S4 + 1 + S1 + 1, 1, 0);
        for (int k = 1; k <= S4 + S1 + 2; k++) begin
            tick(1'b1);
            if (irq_n === 1'b0 && irq_at < 0) irq_at = k;
            if (quarter || half) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL four_step_extra: strobe q=%b h=%b at cycle %0d, required none", quarter, half, k);
                end else begin
                    e = exp_q.pop_front();
                    if (e.at !== k || e.q !== quarter || e.h !== half) begin
                        bad++;
                        $display("[TB] FAIL four_step_event: cycle %0d q=%b h=%b, required cycle %0d q=%b h=%b",
                                 k, quarter, half, e.at, e.q, e.h);
                    end
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL four_step_missing: %0d events left, required 0", exp_q.size());
        end
        exp_q.delete();
        total++;
        if (irq_at != S4 + 1) begin
            bad++;
            $display("[TB] FAIL four_step_irq: irq fell at cycle %0d, required %0d", irq_at, S4 + 1);
        end
    endtask

    task automatic test_status_read();
        logic [7:0] exp;
        rw = 1'b1;
        address = 16'h4016;
        exp_data_q.push_back(8'h00);
        #1;
        exp = exp_data_q.pop_front();
        total++;
        if (data_out !== exp || data_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL other_addr_read: data=%h valid=%b, required data=%h valid=0", data_out, data_valid, exp);
        end
        tick(1'b1);
        total++;
        if (irq_n !== 1'b0) begin
            bad++;
            $display("[TB] FAIL other_addr_keeps_irq: irq_n=%b, required 0", irq_n);
        end
        rw = 1'b0;
        address = APU_STATUS_ADDR;
        #1;
        total++;
        if (data_valid !== 1'b0 || data_out !== 8'h00) begin
            bad++;
            $display("[TB] FAIL status_write_dir: data=%h valid=%b, required data=00 valid=0", data_out, data_valid);
        end
        rw = 1'b1;
        exp_data_q.push_back(8'h40);
        #1;
        exp = exp_data_q.pop_front();
        total++;
        if (data_out !== exp || data_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL status_read_pending: data=%h valid=%b, required data=%h valid=1", data_out, data_valid, exp);
        end
        tick(1'b1);
        exp_data_q.push_back(8'h00);
        exp = exp_data_q.pop_front();
        total++;
        if (data_out !== exp || data_valid !== 1'b1 || irq_n !== 1'b1) begin
            bad++;
            $display("[TB] FAIL status_read_cleared: data=%h valid=%b irq_n=%b, required data=%h valid=1 irq_n=1",
                     data_out, data_valid, irq_n, exp);
        end
        bus_idle();
    endtask

    task automatic test_five_step();
        ev_t e;
        int  irq_lows = 0;
        write_frame(8'h80);
        total++;
        if (quarter !== 1'b1 || half !== 1'b1) begin
            bad++;
            $display("[TB] FAIL five_step_write_strobe: q=%b h=%b, required q=1 h=1", quarter, half);
        end
        push_ev(S1 + 1, 1, 0);
        push_ev(S2 + 1, 1, 1);
        push_ev(S3 + 1, 1, 0);
        push_ev(S5 + 1, 1, 1);
        push_ev(S5 + 1 + S1 + 1, 1, 0);
        for (int k = 1; k <= S5 + S1 + 2; k++) begin
            tick(1'b1);
            if (irq_n !== 1'b1) irq_lows++;
            if (quarter || half) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL five_step_extra: strobe q=%b h=%b at cycle %0d, required none", quarter, half, k);
                end else begin
                    e = exp_q.pop_front();
                    if (e.at !== k || e.q !== quarter || e.h !== half) begin
                        bad++;
                        $display("[TB] FAIL five_step_event: cycle %0d q=%b h=%b, required cycle %0d q=%b h=%b",
                                 k, quarter, half, e.at, e.q, e.h);
                    end
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL five_step_missing: %0d events left, required 0", exp_q.size());
        end
        exp_q.delete();
        total++;
        if (irq_lows != 0) begin
            bad++;
            $display("[TB] FAIL five_step_no_irq: irq low for %0d cycles, required 0", irq_lows);
        end
    endtask

    task automatic test_inhibit();
        int irq_lows = 0;
        int quarters = 0;
        write_frame(8'h00);
        total++;
        if (quarter !== 1'b0 || half !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mode0_write_no_strobe: q=%b h=%b, required q=0 h=0", quarter, half);
        end
        repeat (S4 + 1) tick(1'b1);
        total++;
        if (irq_n !== 1'b0) begin
            bad++;
            $display("[TB] FAIL inhibit_setup_irq: irq_n=%b, required 0", irq_n);
        end
        write_frame(8'h40);
        total++;
        if (irq_n !== 1'b1) begin
            bad++;
            $display("[TB] FAIL inhibit_clears_irq: irq_n=%b, required 1", irq_n);
        end
        for (int k = 1; k <= S4 + 2; k++) begin
            tick(1'b1);
            if (irq_n !== 1'b1) irq_lows++;
            if (quarter === 1'b1) quarters++;
        end
        total++;
        if (irq_lows != 0) begin
            bad++;
            $display("[TB] FAIL inhibit_no_irq: irq low for %0d cycles, required 0", irq_lows);
        end
        total++;
        if (quarters != 4) begin
            bad++;
            $display("[TB] FAIL inhibit_quarters: %0d quarter strobes, required 4", quarters);
        end
    endtask

    task automatic test_coincident();
        int first_q = -1;
        // IRQ set and $4015 read clear on the same edge
        write_frame(8'h00);
        repeat (S4) tick(1'b1);
        rw = 1'b1;
        address = APU_STATUS_ADDR;
        tick(1'b1);
        total++;
        if (irq_n !== 1'b0 || quarter !== 1'b1 || half !== 1'b1) begin
            bad++;
            $display("[TB] FAIL set_beats_read: irq_n=%b q=%b h=%b, required irq_n=0 q=1 h=1", irq_n, quarter, half);
        end
        total++;
        if (data_out !== 8'h40) begin
            bad++;
            $display("[TB] FAIL read_after_set: data=%h, required 40", data_out);
        end
        tick(1'b1);
        bus_idle();
        total++;
        if (irq_n !== 1'b1) begin
            bad++;
            $display("[TB] FAIL read_clears_later: irq_n=%b, required 1", irq_n);
        end
        // IRQ set coinciding with an inhibiting $4017 write
        write_frame(8'h00);
        repeat (S4) tick(1'b1);
        write_frame(8'h40);
        total++;
        if (irq_n !== 1'b1 || quarter !== 1'b0 || half !== 1'b0) begin
            bad++;
            $display("[TB] FAIL write_beats_step4: irq_n=%b q=%b h=%b, required irq_n=1 q=0 h=0", irq_n, quarter, half);
        end
        // $4017 write landing on STEP3
        write_frame(8'h00);
        repeat (S3) tick(1'b1);
        write_frame(8'h00);
        total++;
        if (quarter !== 1'b0 || half !== 1'b0) begin
            bad++;
            $display("[TB] FAIL write_on_step3: q=%b h=%b, required q=0 h=0", quarter, half);
        end
        for (int k = 1; k <= S1 + 1; k++) begin
            tick(1'b1);
            if (quarter === 1'b1 && first_q < 0) first_q = k;
        end
        total++;
        if (first_q != S1 + 1) begin
            bad++;
            $display("[TB] FAIL step3_restart: first quarter at cycle %0d, required %0d", first_q, S1 + 1);
        end
    endtask

    task automatic test_clk_en_reset();
        ev_t  e;
        int   irq_at = -1;
        int   hold_bad = 0;
        int   first_q = -1;
        logic q0, h0, irq0;
        write_frame(8'h00);
        push_ev(S1 + 1, 1, 0);
        push_ev(S2 + 1, 1, 1);
        push_ev(S3 + 1, 1, 0);
        push_ev(S4 + 1, 1, 1);
        push_ev(S4 + 1 + S1 + 1, 1, 0);
        for (int k = 1; k <= S4 + S1 + 2; k++) begin
            tick(1'b1);
            q0 = quarter;
            h0 = half;
            irq0 = irq_n;
            if (irq_n === 1'b0 && irq_at < 0) irq_at = k;
            if (quarter || half) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL gated_extra: strobe q=%b h=%b at enabled cycle %0d, required none", quarter, half, k);
                end else begin
                    e = exp_q.pop_front();
                    if (e.at !== k || e.q !== quarter || e.h !== half) begin
                        bad++;
                        $display("[TB] FAIL gated_event: cycle %0d q=%b h=%b, required cycle %0d q=%b h=%b",
                                 k, quarter, half, e.at, e.q, e.h);
                    end
                end
            end
            tick(1'b0);
            tick(1'b0);
            if (quarter !== q0 || half !== h0 || irq_n !== irq0) hold_bad++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL gated_missing: %0d events left, required 0", exp_q.size());
        end
        exp_q.delete();
        total++;
        if (hold_bad != 0) begin
            bad++;
            $display("[TB] FAIL gated_hold: %0d disabled cycles changed outputs, required 0", hold_bad);
        end
        total++;
        if (irq_at != S4 + 1) begin
            bad++;
            $display("[TB] FAIL gated_irq: irq fell at enabled cycle %0d, required %0d", irq_at, S4 + 1);
        end
        reset_n = 1'b0;
        tick(1'b1);
        total++;
        if (irq_n !== 1'b1 || quarter !== 1'b0 || half !== 1'b0 || data_out !== 8'h00) begin
            bad++;
            $display("[TB] FAIL mid_reset: irq_n=%b q=%b h=%b data=%h, required irq_n=1 q=0 h=0 data=00",
                     irq_n, quarter, half, data_out);
        end
        reset_n = 1'b1;
        for (int k = 1; k <= S1 + 1; k++) begin
            tick(1'b1);
            if (quarter === 1'b1 && first_q < 0) first_q = k;
            tick(1'b0);
            tick(1'b0);
        end
        total++;
        if (first_q != S1 + 1) begin
            bad++;
            $display("[TB] FAIL reset_restart: first quarter at enabled cycle %0d, required %0d", first_q, S1 + 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting apu_frame_counter bench");
        test_reset();
        test_four_step();
        test_status_read();
        test_five_step();
        test_inhibit();
        test_coincident();
        test_clk_en_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
